// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester stage.
package apb_pkg;

  localparam int SLAVE_ID_W = 2;
  localparam int NUM_SLAVES = 4;

  // Default bus widths, matching the slave-with-memory instances
  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  // Command as presented by the local requester (default widths)
  typedef struct packed {
    logic                  write;
    logic [SLAVE_ID_W-1:0] id;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

  // Response as returned to the local requester (default widths)
  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_resp_t;

  // One-hot slave select for a given slave id
  function automatic logic [NUM_SLAVES-1:0] slave_sel(input logic [SLAVE_ID_W-1:0] id);
    logic [NUM_SLAVES-1:0] sel;
    sel     = '0;
    sel[id] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/apb_timeout_ctr.sv
// Counts ACCESS wait cycles and flags the cycle on which a transfer
// must be forcibly terminated. TIMEOUT = 0 disables the flag entirely.
module apb_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // A zero-width counter is illegal, so keep at least one bit when disabled
  localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LAST = CW'(LAST_I);

  logic [CW-1:0] count;

  // Wait-cycle counter: cleared outside ACCESS, saturates at the expiry value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (TIMEOUT != 0) && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/apb_master_ctrl.sv
// APB requester: turns single valid/ready commands into one APB transfer
// to one of four slaves and returns data/error over a valid/ready response.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [SLAVE_ID_W-1:0] req_id,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  resp_timeout,
  output logic [NUM_SLAVES-1:0] psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  apb_state_e state;
  logic       to_clear;
  logic       to_enable;
  logic       to_expired;

  // The counter only runs while ACCESS is waiting on the slave
  assign to_clear  = (state != ACCESS);
  assign to_enable = (state == ACCESS) && !pready;

  apb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (to_clear),
    .enable (to_enable),
    .expired(to_expired)
  );

  // Transfer FSM; the registered bus outputs double as the command holding
  // registers, so psel/paddr are already valid in the SETUP cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      resp_timeout <= 1'b0;
      psel         <= '0;
      penable      <= 1'b0;
      pwrite       <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            psel      <= slave_sel(req_id);
            penable   <= 1'b0;
            pwrite    <= req_write;
            paddr     <= req_addr;
            pwdata    <= req_write ? req_wdata : '0;
            state     <= SETUP;
          end
        end

        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          if (pready) begin
            psel         <= '0;
            penable      <= 1'b0;
            resp_valid   <= 1'b1;
            resp_err     <= pslverr;
            resp_timeout <= 1'b0;
            resp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
            state        <= RESP;
          end else if (to_expired) begin
            psel         <= '0;
            penable      <= 1'b0;
            resp_valid   <= 1'b1;
            resp_err     <= 1'b1;
            resp_timeout <= 1'b1;
            resp_rdata   <= '0;
            state        <= RESP;
          end
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_timeout <= 1'b0;
            resp_rdata   <= '0;
            req_ready    <= 1'b1;
            state        <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: table of transfers with a simple
// APB slave responder, plus backpressure and mid-transfer reset sequences.
module tb_apb_master_ctrl;
  import apb_pkg::*;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_id;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_timeout;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    apb_req_t    req;
    int          ready_at;
    logic [31:0] prdata;
    logic        pslverr;
    apb_resp_t   exp;
    logic [3:0]  exp_psel;
    int          exp_acc;
  } vec_t;

  vec_t vecs[7];
  vec_t bp_vec;
  vec_t rst_vec;

  apb_master_ctrl #(
    .ADDR_W (8),
    .DATA_W (32),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_id      (req_id),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .resp_timeout(resp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  always #5 clk = ~clk;

  // Bus protocol watch: psel one-hot or zero, penable never without psel
  always @(negedge clk) begin
    total++;
    if ((penable && (psel == 4'b0000)) ||
        !(psel inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000})) begin
      bad++;
      $display("[TB] FAIL protocol: psel=%b penable=%b required one-hot psel with penable", psel, penable);
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time expired, required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mkVec(input logic wr, input logic [1:0] id, input logic [7:0] addr,
                                 input logic [31:0] wdata, input int ready_at,
                                 input logic [31:0] rd, input logic err_in,
                                 input logic [31:0] exp_rdata, input logic exp_err,
                                 input logic exp_to, input logic [3:0] exp_psel, input int exp_acc);
    vec_t v;
    v.req.write     = wr;
    v.req.id        = id;
    v.req.addr      = addr;
    v.req.wdata     = wdata;
    v.ready_at      = ready_at;
    v.prdata        = rd;
    v.pslverr       = err_in;
    v.exp.rdata     = exp_rdata;
    v.exp.err       = exp_err;
    v.exp.timeout   = exp_to;
    v.exp_psel      = exp_psel;
    v.exp_acc       = exp_acc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
    end
  endtask

  // One complete transfer; bp > 0 holds the response for bp cycles while a
  // follow-up write to slave 2 is offered, and leaves that request pending
  task automatic applyStimulus(input vec_t v, input int bp);
    int  n;
    int  acc;
    bit  done;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = v.req.write;
    req_id    = v.req.id;
    req_addr  = v.req.addr;
    req_wdata = v.req.wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = ~v.req.write;
    req_id    = v.req.id + 2'd1;
    req_addr  = ~v.req.addr;
    req_wdata = ~v.req.wdata;

    @(negedge clk);
    checkOutput("setup_psel", psel, v.exp_psel);
    checkOutput("setup_penable", penable, 1'b0);
    checkOutput("setup_pwrite", pwrite, v.req.write);
    checkOutput("setup_paddr", paddr, v.req.addr);
    checkOutput("setup_pwdata", pwdata, v.req.write ? v.req.wdata : 32'h0);
    checkOutput("setup_req_ready", req_ready, 1'b0);
    checkOutput("setup_resp_valid", resp_valid, 1'b0);
    @(posedge clk);
    #1;

    acc  = 0;
    done = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        done = 1'b1;
      end else begin
        acc++;
        checkOutput("access_penable", penable, 1'b1);
        checkOutput("access_psel", psel, v.exp_psel);
        checkOutput("access_paddr", paddr, v.req.addr);
        checkOutput("access_pwrite", pwrite, v.req.write);
        if (acc == v.ready_at) begin
          pready  = 1'b1;
          prdata  = v.prdata;
          pslverr = v.pslverr;
        end else begin
          pready  = 1'b0;
          prdata  = 32'hA5A5A5A5;
          pslverr = 1'b0;
        end
        @(posedge clk);
        #1;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h5A5A5A5A;
      end
    end
    checkOutput("resp_seen", done, 1'b1);
    checkOutput("access_cycles", acc, v.exp_acc);
    checkOutput("resp_psel", psel, 4'b0000);
    checkOutput("resp_penable", penable, 1'b0);
    checkOutput("resp_rdata", resp_rdata, v.exp.rdata);
    checkOutput("resp_err", resp_err, v.exp.err);
    checkOutput("resp_timeout", resp_timeout, v.exp.timeout);
    checkOutput("resp_req_ready", req_ready, 1'b0);

    for (int b = 0; b < bp; b++) begin
      if (b == 0) begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_id    = 2'd2;
        req_addr  = 8'h55;
        req_wdata = 32'h600DCAFE;
      end
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp_resp_valid", resp_valid, 1'b1);
      checkOutput("bp_req_ready", req_ready, 1'b0);
      checkOutput("bp_rdata", resp_rdata, v.exp.rdata);
      checkOutput("bp_err", resp_err, v.exp.err);
      checkOutput("bp_psel", psel, 4'b0000);
    end

    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    checkOutput("done_resp_valid", resp_valid, 1'b0);
    checkOutput("done_req_ready", req_ready, 1'b1);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_id     = 2'd0;
    req_addr   = 8'h00;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    prdata     = 32'h0;
    pready     = 1'b0;
    pslverr    = 1'b0;

    //            wr    id    addr   wdata          rdy rdata          serr  exp_rdata      err   to    psel     acc
    vecs[0] = mkVec(1'b1, 2'd1, 8'h10, 32'hDEADBEEF, 1, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b0, 4'b0010, 1);
    vecs[1] = mkVec(1'b0, 2'd2, 8'h10, 32'h00000000, 4, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 4'b0100, 4);
    vecs[2] = mkVec(1'b0, 2'd3, 8'h22, 32'h00000000, 1, 32'hCAFEF00D, 1'b1, 32'h00000000, 1'b1, 1'b0, 4'b1000, 1);
    vecs[3] = mkVec(1'b0, 2'd0, 8'h3C, 32'h00000000, 0, 32'h11111111, 1'b0, 32'h00000000, 1'b1, 1'b1, 4'b0001, 4);
    vecs[4] = mkVec(1'b0, 2'd1, 8'h7F, 32'h00000000, 4, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 1'b0, 1'b0, 4'b0010, 4);
    vecs[5] = mkVec(1'b1, 2'd3, 8'hFF, 32'h13579BDF, 2, 32'h22222222, 1'b1, 32'h00000000, 1'b1, 1'b0, 4'b1000, 2);
    vecs[6] = mkVec(1'b0, 2'd2, 8'h00, 32'h00000000, 1, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 4'b0100, 1);
    bp_vec  = mkVec(1'b0, 2'd2, 8'h10, 32'h00000000, 1, 32'h11223344, 1'b0, 32'h11223344, 1'b0, 1'b0, 4'b0100, 1);
    rst_vec = mkVec(1'b1, 2'd0, 8'h04, 32'h89ABCDEF, 1, 32'h33333333, 1'b0, 32'h00000000, 1'b0, 1'b0, 4'b0001, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", req_ready, 1'b0);
    checkOutput("rst_resp_valid", resp_valid, 1'b0);
    checkOutput("rst_psel", psel, 4'b0000);
    checkOutput("rst_penable", penable, 1'b0);
    checkOutput("rst_paddr", paddr, 8'h00);
    checkOutput("rst_pwdata", pwdata, 32'h0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_resp_err", resp_err, 1'b0);
    rst_n = 1'b1;

    $display("[TB] table-driven transfers");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], 0);
    end

    $display("[TB] backpressure then reset during ACCESS");
    applyStimulus(bp_vec, 5);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_next_psel", psel, 4'b0100);
    checkOutput("bp_next_penable", penable, 1'b0);
    checkOutput("bp_next_pwrite", pwrite, 1'b1);
    checkOutput("bp_next_paddr", paddr, 8'h55);
    checkOutput("bp_next_pwdata", pwdata, 32'h600DCAFE);
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_penable", penable, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_rst_psel", psel, 4'b0000);
    checkOutput("mid_rst_penable", penable, 1'b0);
    checkOutput("mid_rst_pwrite", pwrite, 1'b0);
    checkOutput("mid_rst_paddr", paddr, 8'h00);
    checkOutput("mid_rst_pwdata", pwdata, 32'h0);
    checkOutput("mid_rst_req_ready", req_ready, 1'b0);
    checkOutput("mid_rst_resp_valid", resp_valid, 1'b0);
    checkOutput("mid_rst_resp_err", resp_err, 1'b0);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("post_rst_no_resp", resp_valid, 1'b0);
    end
    applyStimulus(rst_vec, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
